// File: rtl/seven_seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with a 14-cycle shift-and-add-3 binary-to-BCD converter.
// Optional build macro LEAD_ZERO_BLANK_EN blanks leading zero digits (digit 0 is always shown).
module seven_seg_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] score_in,
  input  logic        load,
  output logic        busy,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       iter_reg, iter_next;
  logic [13:0]      bin_reg, bin_next;
  logic [15:0]      bcd_reg, bcd_next;
  logic [15:0]      disp_reg, disp_next;
  logic [15:0]      bcd_adj;
  logic [13:0]      sat_score;

  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       idx_reg;
  logic [7:0]       seg_reg;
  logic [3:0]       an_reg;
  logic [3:0]       cur_digit;
  logic             blank;
  logic [7:0]       seg_dec;
  logic [3:0]       an_dec;

  function automatic logic [7:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 8'hC0;
      4'd1:    encode = 8'hF9;
      4'd2:    encode = 8'hA4;
      4'd3:    encode = 8'hB0;
      4'd4:    encode = 8'h99;
      4'd5:    encode = 8'h92;
      4'd6:    encode = 8'h82;
      4'd7:    encode = 8'hF8;
      4'd8:    encode = 8'h80;
      4'd9:    encode = 8'h90;
      default: encode = 8'hFF;
    endcase
  endfunction

  assign sat_score = (score_in > 14'd9999) ? 14'd9999 : score_in;

  // Add-3 correction on every BCD nibble before each shift.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    iter_next  = iter_reg;
    bin_next   = bin_reg;
    bcd_next   = bcd_reg;
    disp_next  = disp_reg;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load) begin
          state_next = CONVERT;
          bin_next   = sat_score;
          bcd_next   = '0;
          iter_next  = '0;
        end
      end
      CONVERT: begin
        busy                 = 1'b1;
        {bcd_next, bin_next} = {bcd_adj, bin_reg} << 1;
        iter_next            = iter_reg + 4'd1;
        if (iter_reg == 4'd13) begin
          // Last shift: publish all four digits on the same edge busy drops.
          state_next = IDLE;
          iter_next  = '0;
          disp_next  = bcd_next;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      iter_reg  <= '0;
      bin_reg   <= '0;
      bcd_reg   <= '0;
      disp_reg  <= '0;
    end else begin
      state_reg <= state_next;
      iter_reg  <= iter_next;
      bin_reg   <= bin_next;
      bcd_reg   <= bcd_next;
      disp_reg  <= disp_next;
    end
  end

  assign cur_digit = disp_reg[{idx_reg, 2'b00} +: 4];
  assign an_dec    = ~(4'b0001 << idx_reg);

`ifdef LEAD_ZERO_BLANK_EN
  logic [3:0] zero_above;
  assign zero_above[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_zero
      assign zero_above[gi] = (disp_reg[15:gi*4] == '0);
    end
  endgenerate
  assign blank = zero_above[idx_reg];
`else
  assign blank = 1'b0;
`endif

  assign seg_dec = blank ? 8'hFF : encode(cur_digit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      idx_reg <= '0;
      seg_reg <= 8'hFF;
      an_reg  <= 4'hF;
    end else begin
      if (cnt_reg == CNT_MAX) begin
        cnt_reg <= '0;
        idx_reg <= idx_reg + 2'd1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      an_reg  <= an_dec;
      seg_reg <= seg_dec;
    end
  end

  assign seg = seg_reg;
  assign an  = an_reg;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver: directed and random loads against an arithmetic display model.
// Blanking expectations follow LEAD_ZERO_BLANK_EN as seen by the bench build.
module tb_seven_seg_scan_driver;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [13:0] score_in = '0;
  logic        busy;
  logic [7:0]  seg;
  logic [3:0]  an;

  int checks = 0;
  int failures = 0;
  int n;
  logic [7:0] segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  always #5 clk = ~clk;

  // Rising edges since reset release; the scan slot is derived from this alone.
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  seven_seg_scan_driver #(.REFRESH_DIV(RD)) dut (
    .clk      (clk),
    .rst      (rst),
    .score_in (score_in),
    .load     (load),
    .busy     (busy),
    .seg      (seg),
    .an       (an)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_display(input int val);
    int sat;
    int p;
    int e;
    logic [7:0] es [4];
    logic [3:0] ea;
    sat = (val > 9999) ? 9999 : val;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      es[i] = segtab[(sat / p) % 10];
`ifdef LEAD_ZERO_BLANK_EN
      if (i > 0 && sat < p) es[i] = 8'hFF;
`endif
      p = p * 10;
    end
    for (int c = 0; c < 4 * RD; c++) begin
      @(negedge clk);
      e  = ((n - 1) / RD) % 4;
      ea = ~(4'b0001 << e);
      check($sformatf("an_v%0d_n%0d", val, n), {28'd0, an}, {28'd0, ea});
      check($sformatf("seg_v%0d_idx%0d", val, e), {24'd0, seg}, {24'd0, es[e]});
    end
  endtask

  // Call at a negedge; returns at the first negedge where busy reads 0.
  task automatic do_load(input int val, input int glitch_at, input int glitch_val, output int len);
    score_in = val[13:0];
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    len = 0;
    while (busy === 1'b1 && len < 40) begin
      len++;
      if (len == glitch_at) begin
        load = 1'b1;
        score_in = glitch_val[13:0];
      end
      @(negedge clk);
      load = 1'b0;
    end
    $display("load value=%0d busy_cycles=%0d", val, len);
  endtask

  initial begin
    int len;
    int v1;
    int v2;

    @(negedge clk);
    @(negedge clk);
    check("rst_seg", {24'd0, seg}, 32'hFF);
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_busy", {31'd0, busy}, 32'd0);

    rst = 1'b0;
    check_display(0);

    do_load(1234, 0, 0, len);
    check("busy_len_1234", len, 14);
    check_display(1234);

    do_load(12000, 0, 0, len);
    check("busy_len_12000", len, 14);
    check_display(12000);

    do_load(42, 5, 7, len);
    check("busy_len_42", len, 14);
    @(negedge clk);
    check("ignored_load_busy", {31'd0, busy}, 32'd0);
    check_display(42);

    do_load(5, 0, 0, len);
    check("busy_len_5", len, 14);
    check_display(5);
    do_load(0, 0, 0, len);
    check("busy_len_0", len, 14);
    check_display(0);

    v1 = $urandom_range(0, 16383);
    v2 = $urandom_range(0, 16383);
    do_load(v1, 0, 0, len);
    check("busy_len_b2b_a", len, 14);
    do_load(v2, 0, 0, len);
    check("busy_len_b2b_b", len, 14);
    check_display(v2);

    for (int k = 0; k < 5; k++) begin
      v1 = $urandom_range(0, 16383);
      do_load(v1, 0, 0, len);
      check("busy_len_rand", len, 14);
      check_display(v1);
    end

    score_in = 14'd8888;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 6; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_seg", {24'd0, seg}, 32'hFF);
    check("abort_an", {28'd0, an}, 32'hF);
    @(negedge clk);
    rst = 1'b0;
    check_display(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 The block SHALL have parameter REFRESH_DIV, default 100000, giving clk cycles per digit slot (1 ms at 100 MHz).
REQ-003 Port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 Port score_in, input, 14 bits: unsigned binary score to display.
REQ-006 Port load, input, 1 bit: request to capture score_in.
REQ-007 Port busy, output, 1 bit: high while a binary-to-BCD conversion is in progress.
REQ-008 Port seg, output, 8 bits: active-low cathodes; bit 7 is dp, bits 6:0 are segments g..a.
REQ-009 Port an, output, 4 bits: active-low anodes; an[0] is the rightmost digit.

Function
REQ-010 The block SHALL accept a load only in a cycle where load=1 and busy=0; load while busy=1 SHALL be ignored, with no queuing.
REQ-011 On acceptance the block SHALL capture score_in, saturated to 9999 if greater, and assert busy from the next cycle.
REQ-012 Conversion SHALL use shift-and-add-3 with one iteration per clock and exactly 14 iterations; busy SHALL be high for exactly 14 cycles.
REQ-013 The four BCD display registers SHALL update atomically on the clock edge where busy falls; during conversion the previous value stays displayed.
REQ-014 A load may be accepted in the first cycle busy reads 0, giving back-to-back conversions with no dead cycle.
REQ-015 The state machine SHALL have states IDLE (busy=0) and CONVERT (busy=1): IDLE->CONVERT on an accepted load; CONVERT->IDLE when the iteration counter reaches 13.
REQ-016 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap, the 2-bit digit index SHALL increment modulo 4 (0,1,2,3,0).
REQ-017 an SHALL be registered and one-hot low for the active index (idx 0 -> 1110, idx 3 -> 0111).
REQ-018 seg SHALL be registered, change on the same edge as an, and keep dp (bit 7) at 1 at all times.
REQ-019 seg SHALL encode BCD digits in hex as: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90; any other value gives FF.
REQ-020 Scanning SHALL continue unaffected by load, busy or conversion activity.

Reset
REQ-021 While rst=1 the outputs SHALL be seg=FF, an=F and busy=0.
REQ-022 While rst=1 the displayed value, refresh counter, digit index and iteration counter SHALL all be 0 and the state SHALL be IDLE.
REQ-023 rst asserted mid-conversion SHALL abort the conversion; the displayed value after reset is 0000.
REQ-024 On the first clock edge after rst falls, the block SHALL drive an=1110 and seg=C0.

Configuration
REQ-025 The block SHALL support the macro LEAD_ZERO_BLANK_EN.
REQ-026 With LEAD_ZERO_BLANK_EN defined, positions 3..1 SHALL show seg=FF when that digit and every higher digit are zero; an still scans normally, and digit 0 is always shown.
REQ-027 Without LEAD_ZERO_BLANK_EN, all four digits SHALL always be shown, including leading zeros.

Verification
REQ-028 The bench SHALL apply reset, release it and observe for 4*REFRESH_DIV cycles (REFRESH_DIV=4): an cycles 1110, 1101, 1011, 0111, each for 4 cycles, and seg=C0 throughout (macro off).
REQ-029 The bench SHALL load 1234 while idle: busy is high for 14 cycles; then the slots idx 0..3 show seg 99, B0, A4, F9.
REQ-030 The bench SHALL load 12000: the display saturates, with every slot showing 90 (9999).
REQ-031 The bench SHALL load 42, then pulse load with 7 at conversion cycle 5: the second load is ignored, the display shows 0042, and busy falls after 14 cycles.
REQ-032 The bench SHALL define LEAD_ZERO_BLANK_EN and load 5: slots idx 1..3 show FF and idx 0 shows 92; then load 0: idx 0 shows C0.
REQ-033 The bench SHALL assert rst at conversion cycle 7 of a load of 8888: busy=0, seg=FF and an=F immediately; after release the display shows 0000.
